// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t    : serial frame FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : data bits per frame (8N1)
//   UART_IDLE_LEVEL : line level while no frame is being sent
//   bit_div()       : system clocks per bit, truncated integer division
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clocks per bit. The fractional part is dropped; no error accumulation
  // is attempted, so the bit period is slightly short of nominal.
  function automatic int bit_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO feeding the UART transmitter.
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   push, din  : write din when push is high and the FIFO is not full
//   pop        : drop the head entry when pop is high and the FIFO is not empty
//   dout       : current head entry, valid with no read latency while !empty
//   full/empty : status flags, derived directly from the pointers
//   level      : number of stored entries, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  // Same slot, different lap -> full; identical pointers -> empty.
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign level     = wr_ptr_r - rd_ptr_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset flushes the queue by equalising the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
//   sys_clk, sys_rst_n : clock (posedge) and asynchronous active-low reset
//   tx_data, tx_valid  : byte stream in; a byte is taken when tx_valid && tx_ready
//   tx_ready           : FIFO has room (not full)
//   uart_tx            : registered serial line, idle high, LSB first
//   tx_busy            : registered; high while a frame is sent or bytes are queued
//   fifo_level         : number of queued bytes, 0..FIFO_DEPTH
// Queued bytes go out back-to-back: the STOP bit expiry pops the next byte
// and re-enters START directly, so no idle bit separates frames.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]        BIT_ONE   = 3'd1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic              uart_tx_r;
  logic              tx_busy_r;
  logic              line_s;
  logic              baud_done_s;
  logic              fifo_pop_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (tx_valid),
    .pop   (fifo_pop_s),
    .din   (tx_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign baud_done_s = (baud_cnt_r == BAUD_LAST);
  assign tx_ready    = !fifo_full_s;
  assign uart_tx     = uart_tx_r;
  assign tx_busy     = tx_busy_r;

  // Next-state and pop decision; pops happen only from IDLE or at STOP expiry.
  always_comb begin
    state_nxt_s = state_r;
    fifo_pop_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          state_nxt_s = S_START;
          fifo_pop_s  = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (baud_done_s && (bit_cnt_r == BIT_LAST)) begin
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_STOP: begin
        if (baud_done_s && !fifo_empty_s) begin
          state_nxt_s = S_START;
          fifo_pop_s  = 1'b1;
        end else if (baud_done_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Line level implied by the current state; registered one cycle later.
  always_comb begin
    line_s = UART_IDLE_LEVEL;
    case (state_r)
      S_START: line_s = 1'b0;
      S_DATA:  line_s = shift_r[0];
      S_IDLE:  line_s = UART_IDLE_LEVEL;
      S_STOP:  line_s = UART_IDLE_LEVEL;
      default: line_s = UART_IDLE_LEVEL;
    endcase
  end

  // FSM, baud/bit counters and shift register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      // The counter restarts on every bit boundary and whenever a frame is loaded.
      if (fifo_pop_s || baud_done_s || (state_r == S_IDLE)) begin
        baud_cnt_r <= '0;
      end else begin
        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
      end
      if (fifo_pop_s) begin
        shift_r   <= fifo_dout_s;
        bit_cnt_r <= '0;
      end else if ((state_r == S_DATA) && baud_done_s) begin
        // Bit 7 wraps the counter back to 0, ready for the next frame.
        shift_r   <= {1'b0, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + BIT_ONE;
      end else if (state_r == S_START) begin
        bit_cnt_r <= '0;
      end
    end
  end

  // Output registers: line follows the state one cycle later; busy looks ahead
  // at the next state so it drops on the very edge that enters IDLE empty.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_tx_r <= UART_IDLE_LEVEL;
      tx_busy_r <= 1'b0;
    end else begin
      uart_tx_r <= line_s;
      tx_busy_r <= (state_nxt_s != S_IDLE) || !fifo_empty_s;
    end
  end

endmodule
